ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver that turns the raw PS/2 clock-edge/data stream into validated scan-code bytes, decodes the 0xE0 (extended) and 0xF0 (break) prefixes, and keeps a held/released state bit for each of NUM_KEYS configurable make codes. It sits between the PS/2 clock-edge detector and game/benchmark control logic. It supersedes the fixed four-key receiver by adding:

- parity and stop-bit checking
- frame timeout
- prefix decoding
- parametrised key table
- typematic hold-off

## Interface
Parameters:
- NUM_KEYS, 4: number of watched keys (1..16).
- KEY_CODES, {8'h1E,8'h16,8'h5A,8'h29}: packed NUM_KEYS×8 make codes; entry i = KEY_CODES[8*i+7:8*i] (default: i0=space 0x29, i1=enter 0x5A, i2='1' 0x16, i3='2' 0x1E).
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk_posedge that abort a frame in progress.
- HOLDOFF_CYCLES, 100: clk cycles after a watched-key break during which make codes do not set key bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- enable  in  1  1 = accept new start bits; 0 = ignore start bits (a frame in progress still completes).
- ps2_clk_posedge  in  1  one-cycle strobe, PS/2 clock rising edge (from edge detector).
- ps2_data  in  1  synchronised PS/2 data line.
- received_data  out  8  last valid byte (prefixes included).
- received_data_en  out  1  one-cycle pulse, received_data updated.
- key_event  out  1  one-cycle pulse, complete (non-prefix) code decoded.
- key_code  out  8  code of the last key_event.
- key_break  out  1  key_code was preceded by 0xF0.
- key_extended  out  1  key_code was preceded by 0xE0.
- frame_error  out  1  one-cycle pulse on parity, stop or timeout error.
- key_pressed  out  NUM_KEYS  bit i = watched key i currently held.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE→DATA: at a ps2_clk_posedge with ps2_data=0 and enable=1.
- DATA: shift ps2_data in LSB first at each posedge. After the 8th bit, go to PARITY. The bit counter is 3 bits and wraps 7→0.
- PARITY: sample the parity bit at posedge, then go to STOP. Parity is odd: the data bits plus the parity bit must contain an odd number of ones.
- STOP: sample the stop bit at posedge, then go to IDLE.
  - Valid frame (parity good, stop=1): load received_data and pulse received_data_en.
  - Invalid frame: pulse frame_error and clear both pending-prefix flags. No data pulse.
- Timeout: the idle counter runs in DATA/PARITY/STOP and clears on every posedge. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear prefix flags, discard the partial byte.
- Byte decode (valid frames only):
  - 0xE0 sets ext_pending.
  - 0xF0 sets brk_pending.
  - Any other byte: pulse key_event with key_code=byte, key_break=brk_pending, key_extended=ext_pending, then clear both flags.
- Key table: on key_event with key_extended=0, every entry i whose code equals key_code updates. Duplicate entries all update.
  - Break: key_pressed[i]←0 and the hold-off counter loads HOLDOFF_CYCLES.
  - Make: key_pressed[i]←1 only if the hold-off counter is 0; otherwise ignored.
- Hold-off counter: decrements to 0 and saturates there. A break during hold-off reloads it. Break codes are always honoured.
- Extended codes never touch key_pressed.
- Typematic repeat makes for an already-held key leave the bit at 1.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; prefix flags 0; shift register 0x00.
- Latency: received_data, received_data_en, key_event, key_code, key_break, key_extended, key_pressed and frame_error all update on the clk edge that samples the stop-bit posedge. They are visible in the following cycle, and all pulses are exactly 1 cycle.
- A byte spans 11 ps2_clk_posedge strobes: start, 8 data, parity, stop.
- A start bit is accepted on the posedge after STOP→IDLE; no dead cycles.
- A strobe in IDLE with ps2_data=1, or with enable=0, is ignored.
- Dropping enable mid-frame does not abort the frame.
- Reset asserted mid-frame: immediate return to IDLE; the next frame needs a fresh start bit.
- The timeout counter and hold-off counter widths are $clog2 of their parameter plus 1; no overflow is possible.

## Test plan
- Send 0x29 (parity bit 0), then 0xF0, then 0x29, with a gap over HOLDOFF_CYCLES → key_pressed[0] rises one cycle after the first frame's stop bit, then falls; received_data_en pulses 3 times; key_event pulses 2 times, the second with key_break=1.
- Send E0, 5A → key_event with key_code=0x5A, key_extended=1; key_pressed stays 4'b0000.
- Send 0x16 with a wrong parity bit → frame_error pulses once; no received_data_en; key_pressed[2]=0. Then send a good 0x16 → key_pressed[2]=1.
- Send start bit plus 3 data bits, then no strobes for TIMEOUT_CYCLES → frame_error pulses and state is IDLE. A following good 0x1E sets key_pressed[3].
- Send F0, 1E, then 1E again within HOLDOFF_CYCLES → key_pressed[3] stays 0. Send 1E after the hold-off has expired → key_pressed[3]=1.
- Pull reset low mid-frame while key_pressed=4'b0011 → all outputs 0 asynchronously. A subsequent full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with prefix decode and watched-key state
module ps2_keyboard_rx #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h1E, 8'h16, 8'h5A, 8'h29},
  parameter int                    TIMEOUT_CYCLES = 50000,
  parameter int                    HOLDOFF_CYCLES = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ps2_clk_posedge,
  input  logic                ps2_data,
  output logic [7:0]          received_data,
  output logic                received_data_en,
  output logic                key_event,
  output logic [7:0]          key_code,
  output logic                key_break,
  output logic                key_extended,
  output logic                frame_error,
  output logic [NUM_KEYS-1:0] key_pressed
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] idle_cnt;
  logic [HW-1:0] holdoff_cnt;
  logic          ext_pending;
  logic          brk_pending;

  logic [NUM_KEYS-1:0] key_match;
  logic                frame_ok;
  logic                is_key_byte;
  logic                stop_valid;
  logic                watched_break;

  always_comb begin
    key_match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_match[i] = (KEY_CODES[8*i +: 8] == shift_reg);
    end
  end

  // Odd parity over data+parity, and the stop bit (sampled live) must be 1.
  assign frame_ok      = ps2_data && (^{shift_reg, parity_bit});
  assign is_key_byte   = (shift_reg != 8'hE0) && (shift_reg != 8'hF0);
  assign stop_valid    = (state == STOP) && ps2_clk_posedge && frame_ok;
  assign watched_break = stop_valid && is_key_byte && !ext_pending && brk_pending && (|key_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      parity_bit       <= 1'b0;
      idle_cnt         <= '0;
      holdoff_cnt      <= '0;
      ext_pending      <= 1'b0;
      brk_pending      <= 1'b0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      key_event        <= 1'b0;
      key_code         <= '0;
      key_break        <= 1'b0;
      key_extended     <= 1'b0;
      frame_error      <= 1'b0;
      key_pressed      <= '0;
    end else begin
      received_data_en <= 1'b0;
      key_event        <= 1'b0;
      frame_error      <= 1'b0;

      if (watched_break) begin
        holdoff_cnt <= HOLDOFF_LOAD;
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end

      if (state == IDLE) begin
        idle_cnt <= '0;
        if (ps2_clk_posedge && !ps2_data && enable) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (ps2_clk_posedge) begin
        idle_cnt <= '0;
        if (state == DATA) begin
          shift_reg <= {ps2_data, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= PARITY;
          end
        end else if (state == PARITY) begin
          parity_bit <= ps2_data;
          state      <= STOP;
        end else begin
          state <= IDLE;
          if (frame_ok) begin
            received_data    <= shift_reg;
            received_data_en <= 1'b1;
            if (shift_reg == 8'hE0) begin
              ext_pending <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
              brk_pending <= 1'b1;
            end else begin
              key_event    <= 1'b1;
              key_code     <= shift_reg;
              key_break    <= brk_pending;
              key_extended <= ext_pending;
              ext_pending  <= 1'b0;
              brk_pending  <= 1'b0;
              // Extended codes share make codes with plain keys but never touch the table.
              if (!ext_pending) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                  if (key_match[i]) begin
                    if (brk_pending) begin
                      key_pressed[i] <= 1'b0;
                    end else if (holdoff_cnt == '0) begin
                      key_pressed[i] <= 1'b1;
                    end
                  end
                end
              end
            end
          end else begin
            frame_error <= 1'b1;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
          end
        end
      end else if (idle_cnt == TIMEOUT_LAST) begin
        state       <= IDLE;
        idle_cnt    <= '0;
        shift_reg   <= '0;
        frame_error <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx with a frame-level reference model
module tb_ps2_keyboard_rx;

  localparam int T = 300;
  localparam int H = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       ps2_clk_posedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       key_event;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_extended;
  logic       frame_error;
  logic [3:0] key_pressed;

  ps2_keyboard_rx #(
    .NUM_KEYS(4),
    .KEY_CODES({8'h1E, 8'h16, 8'h5A, 8'h29}),
    .TIMEOUT_CYCLES(T),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_data(ps2_data),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .key_event(key_event),
    .key_code(key_code),
    .key_break(key_break),
    .key_extended(key_extended),
    .frame_error(frame_error),
    .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] codes [4] = '{8'h29, 8'h5A, 8'h16, 8'h1E};
  logic [7:0] m_rd, m_kc;
  logic       m_kb, m_kx, m_ext, m_brk;
  logic [3:0] m_pressed;
  longint     m_last_break;
  logic       e_en, e_ev, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 8'h00; m_kc = 8'h00; m_kb = 1'b0; m_kx = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_pressed = 4'b0000;
    m_last_break = -1000000;
    e_en = 1'b0; e_ev = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok, input longint edge_c);
    bit hit;
    hit = 1'b0;
    e_en = 1'b0; e_ev = 1'b0; e_err = 1'b0;
    if (!ok) begin
      e_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      e_en = 1'b1;
      m_rd = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        e_ev = 1'b1; m_kc = b; m_kb = m_brk; m_kx = m_ext;
        if (!m_ext) begin
          for (int i = 0; i < 4; i++) begin
            if (codes[i] == b) begin
              if (m_brk) begin
                m_pressed[i] = 1'b0;
                hit = 1'b1;
              end else if (edge_c - m_last_break > H) begin
                m_pressed[i] = 1'b1;
              end
            end
          end
          if (hit) m_last_break = edge_c;
        end
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_en"}, received_data_en, e_en);
    chk({tag, ".ferr"}, frame_error, e_err);
    chk({tag, ".kev"}, key_event, e_ev);
    chk({tag, ".rd"}, received_data, m_rd);
    chk({tag, ".kcode"}, key_code, m_kc);
    chk({tag, ".kbrk"}, key_break, m_kb);
    chk({tag, ".kext"}, key_extended, m_kx);
    chk({tag, ".pressed"}, key_pressed, m_pressed);
    @(negedge clk);
    chk({tag, ".rd_en_end"}, received_data_en, 1'b0);
    chk({tag, ".kev_end"}, key_event, 1'b0);
    chk({tag, ".ferr_end"}, frame_error, 1'b0);
  endtask

  task automatic strobe(input logic d);
    @(negedge clk);
    ps2_data = d;
    ps2_clk_posedge = 1'b1;
    @(negedge clk);
    ps2_clk_posedge = 1'b0;
    ps2_data = 1'b1;
  endtask

  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  // en_mode: 0 enabled, 1 enable dropped after start bit, 2 disabled throughout
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int en_mode, output longint edge_c);
    enable = (en_mode != 2);
    strobe(1'b0); gap();
    if (en_mode == 1) enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(b[i]); gap();
    end
    strobe((~^b) ^ bad_par); gap();
    strobe(~bad_stop);
    edge_c = cyc;
    enable = 1'b1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bp, input bit bs, input int em);
    longint e;
    send_bits(b, bp, bs, em, e);
    if (em == 2) begin
      e_en = 1'b0; e_ev = 1'b0; e_err = 1'b0;
    end else begin
      model_frame(b, !bp && !bs, e);
    end
    check_all(tag);
    gap();
  endtask

  task automatic do_timeout(input string tag, input logic [7:0] b, input int nbits);
    longint l;
    bit seen;
    seen = 1'b0;
    strobe(1'b0); gap();
    for (int i = 0; i < nbits; i++) begin
      strobe(b[i]);
      if (i != nbits - 1) gap();
    end
    l = cyc;
    for (int k = 0; k < T + 20 && !seen; k++) begin
      @(negedge clk);
      if (frame_error) seen = 1'b1;
    end
    chk({tag, ".seen"}, seen, 1'b1);
    chk({tag, ".latency"}, 32'(cyc - l), T);
    chk({tag, ".rd_en"}, received_data_en, 1'b0);
    chk({tag, ".pressed"}, key_pressed, m_pressed);
    m_ext = 1'b0; m_brk = 1'b0;
    @(negedge clk);
    chk({tag, ".ferr_end"}, frame_error, 1'b0);
    gap();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rd"}, received_data, 8'h00);
    chk({tag, ".rd_en"}, received_data_en, 1'b0);
    chk({tag, ".kev"}, key_event, 1'b0);
    chk({tag, ".kcode"}, key_code, 8'h00);
    chk({tag, ".kbrk"}, key_break, 1'b0);
    chk({tag, ".kext"}, key_extended, 1'b0);
    chk({tag, ".ferr"}, frame_error, 1'b0);
    chk({tag, ".pressed"}, key_pressed, 4'b0000);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    gap();

    // make, break, make gap beyond hold-off
    do_frame("mk29", 8'h29, 0, 0, 0);
    chk("mk29.bit0", key_pressed[0], 1'b1);
    repeat (H + 20) @(negedge clk);
    do_frame("f0", 8'hF0, 0, 0, 0);
    do_frame("brk29", 8'h29, 0, 0, 0);
    chk("brk29.bit0", key_pressed[0], 1'b0);
    repeat (H + 20) @(negedge clk);

    do_frame("e0", 8'hE0, 0, 0, 0);
    do_frame("ext5a", 8'h5A, 0, 0, 0);
    chk("ext5a.none", key_pressed, 4'b0000);

    do_frame("bad16", 8'h16, 1, 0, 0);
    do_frame("good16", 8'h16, 0, 0, 0);
    chk("good16.bit2", key_pressed[2], 1'b1);

    do_frame("e0_to", 8'hE0, 0, 0, 0);
    do_timeout("timeout", 8'h1E, 3);
    do_frame("mk1e", 8'h1E, 0, 0, 0);
    chk("mk1e.bit3", key_pressed[3], 1'b1);

    do_frame("f0b", 8'hF0, 0, 0, 0);
    do_frame("brk1e", 8'h1E, 0, 0, 0);
    do_frame("mk1e_hold", 8'h1E, 0, 0, 0);
    chk("mk1e_hold.bit3", key_pressed[3], 1'b0);
    repeat (H + 20) @(negedge clk);
    do_frame("mk1e_late", 8'h1E, 0, 0, 0);
    chk("mk1e_late.bit3", key_pressed[3], 1'b1);

    do_frame("badstop", 8'h5A, 0, 1, 0);
    do_frame("dis", 8'h16, 0, 0, 2);
    do_frame("drop_en", 8'h29, 0, 0, 1);

    // reach 4'b0011 then reset mid-frame
    do_frame("f0c", 8'hF0, 0, 0, 0);
    do_frame("brk16", 8'h16, 0, 0, 0);
    do_frame("f0d", 8'hF0, 0, 0, 0);
    do_frame("brk1e2", 8'h1E, 0, 0, 0);
    repeat (H + 20) @(negedge clk);
    do_frame("mk29b", 8'h29, 0, 0, 0);
    do_frame("mk5a", 8'h5A, 0, 0, 0);
    chk("pre_reset.pressed", key_pressed, 4'b0011);
    strobe(1'b0); gap();
    strobe(1'b1); gap();
    strobe(1'b0);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    gap();
    do_frame("post_reset", 8'h5A, 0, 0, 0);

    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) b = codes[r];
      else if (r == 4) b = 8'hE0;
      else if (r == 5) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin
        strobe(1'b1); gap();
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 130)) @(negedge clk);
      do_frame($sformatf("rnd%0d", n), b,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
